pkt_addr_alloc: RTL and testbench

Parametrised successor of the packet SG/address-generation stage in the shared-SRAM switch. It buffers packet descriptors from the write-lead stage. Packets for an idle output port are cut through directly. All other packets get a contiguous block run in one of BANK_NUM SRAM banks, via the multi-way arbiter, and are then queued to the per-port queue modules. It adds configurable port/bank/depth counts, a round-robin bank-selection mode, wrap-around block masks, and explicit drop handling when no bank has room.

---
 rtl/pkt_sw_pkg.sv | 53 +++++
 rtl/desc_fifo.sv | 70 +++++++
 rtl/pkt_addr_alloc.sv | 253 +++++++++++++++++++++++++
 tb/tb_pkt_addr_alloc.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_sw_pkg.sv
// Shared definitions for the switch address-allocation stage.
//  - clog2-based width helpers (ports, banks, bank depth, free counters)
//  - packet descriptor field offsets: {len, pri[3:0], dest}
//  - queue_info field offsets: {bank, start, len, pri}
//  - one-hot state encoding of the allocation FSM
package pkt_sw_pkg;

  localparam int PRI_W      = 4;
  localparam int DROP_CNT_W = 16;

  // Never returns 0 so that single-entry parameters still give a legal width.
  function automatic int clog2_f(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  // A free counter must be able to hold BANK_DEPTH itself.
  function automatic int cnt_w_f(input int depth);
    return clog2_f(depth) + 1;
  endfunction

  // Descriptor layout, LSB first: dest, pri, len.
  function automatic int desc_pri_lsb(input int dest_w);
    return dest_w;
  endfunction

  function automatic int desc_len_lsb(input int dest_w);
    return dest_w + PRI_W;
  endfunction

  // queue_info layout, LSB first: pri, len, start, bank.
  function automatic int qi_len_lsb();
    return PRI_W;
  endfunction

  function automatic int qi_start_lsb(input int len_w);
    return PRI_W + len_w;
  endfunction

  function automatic int qi_bank_lsb(input int len_w, input int addr_w);
    return PRI_W + len_w + addr_w;
  endfunction

  typedef enum logic [6:0] {
    ST_IDLE  = 7'b000_0001,
    ST_POP   = 7'b000_0010,
    ST_DEC   = 7'b000_0100,
    ST_BYP   = 7'b000_1000,
    ST_REQ   = 7'b001_0000,
    ST_ALLOC = 7'b010_0000,
    ST_DROP  = 7'b100_0000
  } state_e;

endpackage

// File: rtl/desc_fifo.sv
// Synchronous descriptor FIFO with registered read data.
//  clk, rst_n          : clock, asynchronous active-low reset
//  wr_en_i, wr_data_i  : write port; accepted when not full, or when full
//                        and a read happens in the same cycle
//  rd_en_i             : pop; rd_data_o is valid the cycle after
//  full_o, empty_o     : occupancy flags
module desc_fifo
  import pkt_sw_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = clog2_f(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             wr_ok, rd_ok;

  assign full_o    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_ok     = rd_en_i && !empty_o;
  assign wr_ok     = wr_en_i && (!full_o || rd_ok);
  assign rd_data_o = rd_data_q;

  // NOTE: the storage array has no reset; the pointers and count alone
  // define which entries are live, and this keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      count_q <= count_d;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: rtl/pkt_addr_alloc.sv
// Packet address-allocation stage of the shared-SRAM switch.
// Buffers descriptors {len, pri, dest}; cuts packets through to an idle
// port, otherwise allocates a contiguous (wrapping) block run in one SRAM
// bank through the arbiter and writes the result to the per-port queue.
// Ports:
//  sys_clk, sys_rst_n                  clock, async active-low reset
//  pkt_info, pkt_info_vld/_rdy         descriptor input
//  bank_free_cnt, bank_free_addr       per-bank free run (count, start)
//  port_idle                           per-port idle flags
//  data_ren, data_ren_port, por_rd_*   cut-through read and framing
//  req_addr / req_done                 arbiter handshake
//  addr_done, alloc_bank, alloc_mask   allocation commit
//  queue_info_vld, queue_info          queue write (one-hot strobe)
//  drop_pulse, drop_cnt                drop reporting
module pkt_addr_alloc
  import pkt_sw_pkg::*;
#(
  parameter  int PORT_NUM   = 16,
  parameter  int BANK_NUM   = 32,
  parameter  int BANK_DEPTH = 512,
  parameter  int BLK_BYTES  = 64,
  parameter  int LEN_W      = 12,
  parameter  int FIFO_DEPTH = 16,
  parameter  int SEL_MODE   = 0,
  parameter  int BYPASS_EN  = 1,
  localparam int DEST_W     = clog2_f(PORT_NUM),
  localparam int BANK_W     = clog2_f(BANK_NUM),
  localparam int ADDR_W     = clog2_f(BANK_DEPTH),
  localparam int CNT_W      = cnt_w_f(BANK_DEPTH),
  localparam int INFO_W     = LEN_W + PRI_W + DEST_W,
  localparam int QI_W       = BANK_W + ADDR_W + LEN_W + PRI_W
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [INFO_W-1:0]          pkt_info,
  input  logic                       pkt_info_vld,
  output logic                       pkt_info_rdy,
  input  logic [BANK_NUM*CNT_W-1:0]  bank_free_cnt,
  input  logic [BANK_NUM*ADDR_W-1:0] bank_free_addr,
  input  logic [PORT_NUM-1:0]        port_idle,
  output logic                       data_ren,
  output logic [DEST_W-1:0]          data_ren_port,
  output logic                       por_rd_sop,
  output logic                       por_rd_eop,
  output logic                       por_rd_vld,
  output logic                       req_addr,
  input  logic                       req_done,
  output logic                       addr_done,
  output logic [BANK_W-1:0]          alloc_bank,
  output logic [BANK_DEPTH-1:0]      alloc_mask,
  output logic [PORT_NUM-1:0]        queue_info_vld,
  output logic [QI_W-1:0]            queue_info,
  output logic                       drop_pulse,
  output logic [DROP_CNT_W-1:0]      drop_cnt
);

  localparam int PRI_LSB = desc_pri_lsb(DEST_W);
  localparam int LEN_LSB = desc_len_lsb(DEST_W);
  localparam int BLK_SH  = clog2_f(BLK_BYTES);

  // ---------------- helper functions ----------------
  // Bit i is set iff (i - start) mod BANK_DEPTH < blocks.
  function automatic logic [BANK_DEPTH-1:0] gen_mask(input logic [ADDR_W-1:0] start,
                                                     input logic [CNT_W-1:0]  blocks);
    logic [BANK_DEPTH-1:0] m;
    int                    d;
    m = '0;
    for (int i = 0; i < BANK_DEPTH; i++) begin
      d = i - int'(start);
      if (d < 0) d = d + BANK_DEPTH;
      m[i] = (d < int'(blocks));
    end
    return m;
  endfunction

  // First bank, scanning upward from base with wrap, whose free count
  // covers the request. Returns {hit, bank}.
  function automatic logic [BANK_W:0] find_bank(input logic [BANK_NUM*CNT_W-1:0] free_cnt,
                                                input logic [CNT_W-1:0]          need,
                                                input logic [BANK_W-1:0]         base);
    logic              hit;
    logic [BANK_W-1:0] sel;
    int                idx;
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < BANK_NUM; k++) begin
      idx = (int'(base) + k) % BANK_NUM;
      if (!hit && (free_cnt[idx*CNT_W +: CNT_W] >= need)) begin
        hit = 1'b1;
        sel = BANK_W'(idx);
      end
    end
    return {hit, sel};
  endfunction

  // ---------------- descriptor FIFO ----------------
  logic              live_q;        // low in reset and the first cycle after
  logic              fifo_rd, fifo_full, fifo_empty;
  logic [INFO_W-1:0] fifo_rdata;

  desc_fifo #(
    .WIDTH (INFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_desc_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .wr_en_i   (pkt_info_vld && live_q),
    .wr_data_i (pkt_info),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign pkt_info_rdy = live_q && !fifo_full;

  // ---------------- state and datapath registers ----------------
  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, cnt_q;
  logic [PRI_W-1:0]    pri_q;
  logic [DEST_W-1:0]   dest_q;
  logic [CNT_W-1:0]    blocks_q;
  logic [BANK_W-1:0]   bank_q, last_bank_q;
  logic [ADDR_W-1:0]   start_q;
  logic [PORT_NUM-1:0] qvld_q;
  logic [QI_W-1:0]     qinfo_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Decode of the descriptor presented by the FIFO during DEC.
  logic [LEN_W-1:0]  dec_len;
  logic [PRI_W-1:0]  dec_pri;
  logic [DEST_W-1:0] dec_dest;
  logic [LEN_W:0]    dec_blocks;

  assign dec_len    = fifo_rdata[LEN_LSB +: LEN_W];
  assign dec_pri    = fifo_rdata[PRI_LSB +: PRI_W];
  assign dec_dest   = fifo_rdata[0 +: DEST_W];
  assign dec_blocks = ({1'b0, dec_len} + (LEN_W + 1)'(BLK_BYTES - 1)) >> BLK_SH;

  // Bank search
  logic [BANK_W-1:0] search_base;
  logic [BANK_W:0]   search_res;
  logic              search_hit;
  logic [BANK_W-1:0] search_bank;

  always_comb begin
    search_base = '0;
    if (SEL_MODE == 1)
      search_base = (last_bank_q == BANK_W'(BANK_NUM - 1)) ? '0 : last_bank_q + 1'b1;
  end

  assign search_res  = find_bank(bank_free_cnt, blocks_q, search_base);
  assign search_hit  = search_res[BANK_W];
  assign search_bank = search_res[BANK_W-1:0];

  // ---------------- FSM: next state and outputs ----------------
  // NOTE: every signal assigned here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    fifo_rd       = 1'b0;
    data_ren      = 1'b0;
    data_ren_port = '0;
    por_rd_sop    = 1'b0;
    por_rd_eop    = 1'b0;
    por_rd_vld    = 1'b0;
    req_addr      = 1'b0;
    addr_done     = 1'b0;
    alloc_bank    = '0;
    alloc_mask    = '0;
    drop_pulse    = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_POP;
      ST_POP: begin
        fifo_rd = 1'b1;
        state_d = ST_DEC;
      end
      ST_DEC: begin
        if (dec_len == '0 || int'(dec_blocks) > BANK_DEPTH) state_d = ST_DROP;
        else if (BYPASS_EN != 0 && port_idle[dec_dest])     state_d = ST_BYP;
        else                                                state_d = ST_REQ;
      end
      ST_BYP: begin
        data_ren      = 1'b1;
        por_rd_vld    = 1'b1;
        data_ren_port = dest_q;
        por_rd_sop    = (cnt_q == '0);
        por_rd_eop    = (cnt_q == len_q - 1'b1);
        if (por_rd_eop) state_d = ST_IDLE;
      end
      ST_REQ: begin
        req_addr = 1'b1;
        if (req_done) state_d = search_hit ? ST_ALLOC : ST_DROP;
      end
      ST_ALLOC: begin
        addr_done  = 1'b1;
        alloc_bank = bank_q;
        alloc_mask = gen_mask(start_q, blocks_q);
        state_d    = ST_IDLE;
      end
      ST_DROP: begin
        drop_pulse = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      live_q      <= 1'b0;
      len_q       <= '0;
      pri_q       <= '0;
      dest_q      <= '0;
      blocks_q    <= '0;
      cnt_q       <= '0;
      bank_q      <= '0;
      start_q     <= '0;
      last_bank_q <= BANK_W'(BANK_NUM - 1);
      qvld_q      <= '0;
      qinfo_q     <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      qvld_q  <= '0;
      cnt_q   <= (state_q == ST_BYP) ? cnt_q + 1'b1 : '0;
      if (state_q == ST_DEC) begin
        len_q    <= dec_len;
        pri_q    <= dec_pri;
        dest_q   <= dec_dest;
        blocks_q <= CNT_W'(dec_blocks);
      end
      if (state_q == ST_REQ && req_done && search_hit) begin
        bank_q      <= search_bank;
        start_q     <= bank_free_addr[int'(search_bank)*ADDR_W +: ADDR_W];
        last_bank_q <= search_bank;
      end
      // Queue write lands the cycle after the commit strobe.
      if (state_q == ST_ALLOC) begin
        qvld_q  <= {{(PORT_NUM-1){1'b0}}, 1'b1} << dest_q;
        qinfo_q <= {bank_q, start_q, len_q, pri_q};
      end
      if (state_q == ST_DROP && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign queue_info_vld = qvld_q;
  assign queue_info     = qinfo_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_pkt_addr_alloc.sv
// Directed bench for pkt_addr_alloc: one lowest-fit and one round-robin
// instance share the same stimulus.
module tb_pkt_addr_alloc;

  localparam int PORT_NUM = 16, BANK_NUM = 32, BANK_DEPTH = 512, LEN_W = 12;
  localparam int DEST_W = 4, BANK_W = 5, ADDR_W = 9, CNT_W = 10;
  localparam int INFO_W = LEN_W + 4 + DEST_W;
  localparam int QI_W = BANK_W + ADDR_W + LEN_W + 4;

  logic                       sys_clk = 1'b0;
  logic                       sys_rst_n = 1'b0;
  logic [INFO_W-1:0]          pkt_info = '0;
  logic                       pkt_info_vld = 1'b0;
  logic [BANK_NUM*CNT_W-1:0]  bank_free_cnt = '0;
  logic [BANK_NUM*ADDR_W-1:0] bank_free_addr = '0;
  logic [PORT_NUM-1:0]        port_idle = '0;
  logic                       req_done = 1'b0;

  logic                  pkt_info_rdy, data_ren, por_rd_sop, por_rd_eop, por_rd_vld;
  logic [DEST_W-1:0]     data_ren_port;
  logic                  req_addr, addr_done, drop_pulse;
  logic [BANK_W-1:0]     alloc_bank;
  logic [BANK_DEPTH-1:0] alloc_mask;
  logic [PORT_NUM-1:0]   queue_info_vld;
  logic [QI_W-1:0]       queue_info;
  logic [15:0]           drop_cnt;

  logic                  rdy_rr, ren_rr, sop_rr, eop_rr, vld_rr, req_rr, done_rr, drop_rr;
  logic [DEST_W-1:0]     port_rr;
  logic [BANK_W-1:0]     bank_rr;
  logic [BANK_DEPTH-1:0] mask_rr;
  logic [PORT_NUM-1:0]   qvld_rr;
  logic [QI_W-1:0]       qi_rr;
  logic [15:0]           dcnt_rr;

  always #5 sys_clk = ~sys_clk;

  pkt_addr_alloc #(.SEL_MODE(0)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pkt_info(pkt_info),
    .pkt_info_vld(pkt_info_vld), .pkt_info_rdy(pkt_info_rdy),
    .bank_free_cnt(bank_free_cnt), .bank_free_addr(bank_free_addr),
    .port_idle(port_idle), .data_ren(data_ren), .data_ren_port(data_ren_port),
    .por_rd_sop(por_rd_sop), .por_rd_eop(por_rd_eop), .por_rd_vld(por_rd_vld),
    .req_addr(req_addr), .req_done(req_done), .addr_done(addr_done),
    .alloc_bank(alloc_bank), .alloc_mask(alloc_mask),
    .queue_info_vld(queue_info_vld), .queue_info(queue_info),
    .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  pkt_addr_alloc #(.SEL_MODE(1)) u_rr (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pkt_info(pkt_info),
    .pkt_info_vld(pkt_info_vld), .pkt_info_rdy(rdy_rr),
    .bank_free_cnt(bank_free_cnt), .bank_free_addr(bank_free_addr),
    .port_idle(port_idle), .data_ren(ren_rr), .data_ren_port(port_rr),
    .por_rd_sop(sop_rr), .por_rd_eop(eop_rr), .por_rd_vld(vld_rr),
    .req_addr(req_rr), .req_done(req_done), .addr_done(done_rr),
    .alloc_bank(bank_rr), .alloc_mask(mask_rr),
    .queue_info_vld(qvld_rr), .queue_info(qi_rr),
    .drop_pulse(drop_rr), .drop_cnt(dcnt_rr)
  );

  int n_tests = 0, n_fail = 0;
  int n_req = 0, n_alloc = 0, n_drop = 0, n_ren = 0, n_eop = 0;
  logic [BANK_DEPTH-1:0] last_mask;
  logic [BANK_W-1:0]     rr_banks[$];
  logic [QI_W-1:0]       qlog[$];

  // Event monitor, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (req_addr)   n_req++;
      if (drop_pulse) n_drop++;
      if (data_ren)   n_ren++;
      if (por_rd_eop) n_eop++;
      if (addr_done) begin
        n_alloc++;
        last_mask = alloc_mask;
      end
      if (done_rr) rr_banks.push_back(bank_rr);
      if (|queue_info_vld) qlog.push_back(queue_info);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input int len, input int pri, input int dest);
    pkt_info     = {LEN_W'(len), 4'(pri), DEST_W'(dest)};
    pkt_info_vld = 1'b1;
    tick();
    pkt_info_vld = 1'b0;
  endtask

  task automatic set_bank(input int b, input int cnt, input int addr);
    bank_free_cnt[b*CNT_W +: CNT_W]    = CNT_W'(cnt);
    bank_free_addr[b*ADDR_W +: ADDR_W] = ADDR_W'(addr);
  endtask

  task automatic all_banks(input int cnt);
    for (int b = 0; b < BANK_NUM; b++) set_bank(b, cnt, b * 8);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_alloc(input string tag, input int target);
    for (int k = 0; k < 100 && n_alloc < target; k++) tick();
    check(tag, n_alloc, target);
  endtask

  initial begin
    int snap_a, snap_r, snap_e, snap_n;

    // ---- reset state ----
    tick();
    check("rst_rdy_low", pkt_info_rdy, 0);
    do_reset();
    check("rst_rdy", pkt_info_rdy, 1);
    check("rst_outs", {data_ren, por_rd_vld, req_addr, addr_done, drop_pulse}, 0);
    check("rst_qvld", queue_info_vld, 0);
    check("rst_qinfo", queue_info, 0);
    check("rst_dcnt", drop_cnt, 0);

    // ---- cut-through to idle port 5, len 3 ----
    port_idle = 16'h0020;
    snap_r = n_req;
    send(3, 1, 5);
    for (int k = 0; k < 20 && !data_ren; k++) tick();
    check("byp_c1", {data_ren, por_rd_vld, por_rd_sop, por_rd_eop}, 4'b1110);
    check("byp_port", data_ren_port, 5);
    tick();
    check("byp_c2", {data_ren, por_rd_vld, por_rd_sop, por_rd_eop}, 4'b1100);
    tick();
    check("byp_c3", {data_ren, por_rd_vld, por_rd_sop, por_rd_eop}, 4'b1101);
    tick();
    check("byp_end", {data_ren, por_rd_vld}, 0);
    check("byp_noreq", n_req, snap_r);

    // ---- lowest-fit allocation: len 130 -> 3 blocks, bank1 @20 ----
    port_idle = '0;
    req_done  = 1'b1;
    all_banks(0);
    set_bank(0, 2, 100);
    set_bank(1, 10, 20);
    snap_a = n_alloc;
    send(130, 7, 2);
    for (int k = 0; k < 20 && !addr_done; k++) tick();
    check("fit_done", addr_done, 1);
    check("fit_bank", alloc_bank, 1);
    check("fit_mask_pop", $countones(alloc_mask), 3);
    check("fit_mask_bits", {alloc_mask[23], alloc_mask[22:20], alloc_mask[19]}, 5'b01110);
    check("fit_qvld_early", queue_info_vld, 0);
    tick();
    check("fit_qvld", queue_info_vld, 16'h0004);
    check("fit_qinfo", queue_info, {5'd1, 9'd20, 12'd130, 4'd7});
    check("fit_done_low", {addr_done, alloc_bank, $countones(alloc_mask) != 0}, 0);
    tick();
    check("fit_qvld_once", queue_info_vld, 0);
    check("fit_qinfo_hold", queue_info, {5'd1, 9'd20, 12'd130, 4'd7});

    // ---- round-robin: two 1-block packets after reset -> banks 0, 1 ----
    do_reset();
    all_banks(100);
    rr_banks.delete();
    snap_a = n_alloc;
    send(64, 0, 1);
    send(64, 0, 1);
    wait_alloc("rr_two_allocs", snap_a + 2);
    tick();
    check("rr_count", rr_banks.size(), 2);
    if (rr_banks.size() == 2) begin
      check("rr_first", rr_banks[0], 0);
      check("rr_second", rr_banks[1], 1);
    end

    // ---- wrap: bank0 start 511, 2 blocks -> bits 511 and 0 ----
    set_bank(0, 100, 511);
    send(128, 0, 3);
    wait_alloc("wrap_alloc", snap_a + 3);
    check("wrap_mask_pop", $countones(last_mask), 2);
    check("wrap_mask_bits", {last_mask[511], last_mask[510], last_mask[1], last_mask[0]}, 4'b1001);
    tick();
    check("rr_third", rr_banks.size() == 3 ? rr_banks[2] : 5'h1f, 2);

    // ---- drop on no fit, only after req_done ----
    req_done = 1'b0;
    all_banks(0);
    snap_a = n_alloc;
    snap_n = n_drop;
    send(64, 0, 4);
    for (int k = 0; k < 20 && !req_addr; k++) tick();
    check("drop_req", req_addr, 1);
    tick();
    tick();
    check("drop_wait", {req_addr, drop_pulse}, 2'b10);
    req_done = 1'b1;
    for (int k = 0; k < 20 && !drop_pulse; k++) tick();
    check("drop_pulse", drop_pulse, 1);
    tick();
    check("drop_cnt1", drop_cnt, 1);
    check("drop_noalloc", n_alloc, snap_a);
    // len 0 drops without a request
    snap_r = n_req;
    send(0, 0, 4);
    for (int k = 0; k < 20 && !drop_pulse; k++) tick();
    check("drop0_pulse", drop_pulse, 1);
    tick();
    check("drop0_cnt", drop_cnt, 2);
    check("drop0_noreq", n_req, snap_r);
    check("drop_pulses", n_drop, snap_n + 2);

    // ---- backpressure: one packet parked in REQ, 17 writes ----
    req_done = 1'b0;
    all_banks(100);
    send(1000, 2, 9);
    for (int k = 0; k < 20 && !req_addr; k++) tick();
    check("bp_parked", req_addr, 1);
    for (int i = 1; i <= 17; i++) begin
      if (i == 17) check("bp_full", pkt_info_rdy, 0);
      pkt_info     = {LEN_W'(i), 4'(i % 16), DEST_W'(i % 16)};
      pkt_info_vld = 1'b1;
      tick();
    end
    pkt_info_vld = 1'b0;
    check("bp_still_full", pkt_info_rdy, 0);
    qlog.delete();
    req_done = 1'b1;
    for (int k = 0; k < 400 && qlog.size() < 17; k++) tick();
    repeat (20) tick();
    check("bp_retired", qlog.size(), 17);
    if (qlog.size() >= 17) begin
      check("bp_first_len", qlog[0][15:4], 1000);
      for (int i = 1; i <= 16; i++) check($sformatf("bp_len_%0d", i), qlog[i][15:4], i);
    end
    check("bp_rdy_back", pkt_info_rdy, 1);

    // ---- reset in the middle of a cut-through ----
    port_idle = '1;
    send(10, 0, 3);
    send(5, 0, 3);
    for (int k = 0; k < 20 && !data_ren; k++) tick();
    check("mid_byp", data_ren, 1);
    tick();
    tick();
    snap_e = n_eop;
    snap_r = n_ren;
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {data_ren, por_rd_vld, por_rd_sop, por_rd_eop, pkt_info_rdy}, 0);
    check("mid_rst_dcnt", drop_cnt, 0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    repeat (20) tick();
    check("mid_no_eop", n_eop, snap_e);
    check("mid_fifo_flushed", n_ren, snap_r);
    check("mid_rdy", pkt_info_rdy, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
